// File: rtl/afifo_rd_stream_adapter_if.sv
// rtl/afifo_rd_stream_adapter_if.sv - FIFO read port plus valid/ready output stream bundle
// master = adapter side, slave = FIFO/downstream side.
interface afifo_rd_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  rempty,
        input  rdata,
        input  m_ready,
        output rinc,
        output m_valid,
        output m_data
    );

    modport slave (
        output rempty,
        output rdata,
        output m_ready,
        input  rinc,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/afifo_rd_stream_adapter.sv
// rtl/afifo_rd_stream_adapter.sv - async FIFO read-side pop into a 2-entry valid/ready skid buffer
// Optional statistics counters enabled by AFIFO_RD_STAT_EN.
module afifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                          rclk,
    input  logic                          rrst_n,
    afifo_rd_stream_adapter_if.master     bus
`ifdef AFIFO_RD_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0]         rd_count,
    output logic [STAT_WIDTH-1:0]         stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;
    logic                  w_rinc;
    logic                  w_pop;

    // Pop strobe depends only on registered occupancy and rempty, so m_ready
    // never has a combinational path to the FIFO.
    assign w_rinc      = rrst_n & ~bus.rempty & (r_state != ST_FULL);
    assign w_pop       = bus.m_valid & bus.m_ready;
    assign bus.rinc    = w_rinc;
    assign bus.m_valid = (r_state != ST_EMPTY);
    assign bus.m_data  = r_head;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_rinc) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = bus.rdata;
                end
            end
            ST_ONE: begin
                case ({w_rinc, w_pop})
                    2'b10: begin
                        w_state_nxt = ST_FULL;
                        w_tail_nxt  = bus.rdata;
                    end
                    2'b01: w_state_nxt = ST_EMPTY;
                    2'b11: w_head_nxt  = bus.rdata;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = r_tail;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

`ifdef AFIFO_RD_STAT_EN
    logic [STAT_WIDTH-1:0] r_rd_count;
    logic [STAT_WIDTH-1:0] r_stall_count;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rd_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_pop) begin
                r_rd_count <= r_rd_count + 1'b1;
            end
            if ((r_state != ST_FULL) && bus.rempty) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign rd_count    = r_rd_count;
    assign stall_count = r_stall_count;
`else
    if (STAT_WIDTH < 1) begin : g_stat_width_invalid
    end
`endif

endmodule
